rob_alloc_ctrl: RTL and testbench

ROB_ALLOC_CTRL -- requirements
Module: rob_alloc_ctrl

---
 rtl/rob_alloc_ctrl_if.sv | 22 ++
 rtl/rob_alloc_ctrl.sv | 69 ++++++
 tb/tb_rob_alloc_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rob_alloc_ctrl_if.sv
// rob_alloc_ctrl_if: allocation/commit/flush handshake between the ID/ROB stage and the ROB allocator.
interface rob_alloc_ctrl_if #(parameter int ROB_ADDR_WIDTH = 4);
  logic                      flush_req;
  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [ROB_ADDR_WIDTH-1:0] alloc_index;
  logic                      commit_en;
  logic [ROB_ADDR_WIDTH-1:0] commit_index;
  logic [ROB_ADDR_WIDTH:0]   free_count;
  logic                      rob_full;
  logic                      rob_empty;
  logic                      stall_idrob;
  logic                      flush_idrob;
  modport master (
    output flush_req, alloc_valid, commit_en,
    input  alloc_ready, alloc_index, commit_index, free_count, rob_full, rob_empty, stall_idrob, flush_idrob
  );
  modport slave (
    input  flush_req, alloc_valid, commit_en,
    output alloc_ready, alloc_index, commit_index, free_count, rob_full, rob_empty, stall_idrob, flush_idrob
  );
endinterface

// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl: ROB head/tail/occupancy tracking with a RUN/FLUSH recovery FSM.
module rob_alloc_ctrl #(
  parameter int ROB_ADDR_WIDTH = 4,
  parameter int FLUSH_CYCLES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  rob_alloc_ctrl_if.slave    bus
);
  localparam int AW = ROB_ADDR_WIDTH;
  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
  localparam logic [3:0] FC_LD = 4'(FLUSH_CYCLES - 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t        r_state, w_state;
  logic [AW-1:0] r_head, r_tail, w_head, w_tail;
  logic [AW:0]   r_count, w_count;
  logic [3:0]    r_cnt, w_cnt;
  logic          w_full, w_empty, w_alloc, w_commit, w_ready;
  assign w_full   = r_count == DEPTH;
  assign w_empty  = r_count == '0;
  assign w_ready  = (r_state == RUN) && !w_full && !bus.flush_req;
  assign w_alloc  = bus.alloc_valid && w_ready;
  assign w_commit = bus.commit_en && !w_empty && (r_state == RUN) && !bus.flush_req;
  assign bus.alloc_ready  = w_ready;
  assign bus.alloc_index  = r_tail;
  assign bus.commit_index = r_head;
  assign bus.free_count   = DEPTH - r_count;
  assign bus.rob_full     = w_full;
  assign bus.rob_empty    = w_empty;
  assign bus.stall_idrob  = bus.alloc_valid && !w_ready;
  assign bus.flush_idrob  = r_state == FLUSH;
  always_comb begin
    w_state = r_state;
    w_head  = r_head;
    w_tail  = r_tail;
    w_count = r_count;
    w_cnt   = r_cnt;
    if (bus.flush_req) begin
      w_state = FLUSH;
      w_head  = '0;
      w_tail  = '0;
      w_count = '0;
      w_cnt   = FC_LD;
    end else if (r_state == FLUSH) begin
      w_state = (r_cnt == '0) ? RUN : FLUSH;
      w_cnt   = (r_cnt == '0) ? r_cnt : r_cnt - 4'd1;
    end else begin
      // simultaneous alloc and commit leaves occupancy unchanged
      w_head  = r_head + AW'(w_commit);
      w_tail  = r_tail + AW'(w_alloc);
      w_count = r_count + (AW+1)'(w_alloc) - (AW+1)'(w_commit);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RUN;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_head  <= w_head;
      r_tail  <= w_tail;
      r_count <= w_count;
      r_cnt   <= w_cnt;
    end
  end
endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// tb_rob_alloc_ctrl: directed vector table plus fill, full, wrap and reset sequences.
module tb_rob_alloc_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  rob_alloc_ctrl_if #(.ROB_ADDR_WIDTH(4)) bus ();
  rob_alloc_ctrl #(.ROB_ADDR_WIDTH(4), .FLUSH_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic       rs, fl, av, ce;
    logic       rdy;
    logic [3:0] ai, ci;
    logic [4:0] fr;
    logic       full, empty, stall, fid;
  } vec_t;
  localparam int NV = 25;
  vec_t tbl [NV];
  function automatic vec_t v(logic rs, fl, av, ce, rdy, logic [3:0] ai, ci, logic [4:0] fr,
                             logic full, empty, stall, fid);
    return {rs, fl, av, ce, rdy, ai, ci, fr, full, empty, stall, fid};
  endfunction
  function automatic logic [17:0] outs();
    return {bus.alloc_ready, bus.alloc_index, bus.commit_index, bus.free_count,
            bus.rob_full, bus.rob_empty, bus.stall_idrob, bus.flush_idrob};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(logic rs, logic fl, logic av, logic ce);
    rst = rs;
    bus.flush_req = fl;
    bus.alloc_valid = av;
    bus.commit_en = ce;
    #4;
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
  endtask
  localparam logic [17:0] RST_OUT = {1'b1, 4'd0, 4'd0, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0};
  initial begin
    tbl[0]  = v(1,0,0,0, 1,0,0,16,0,1,0,0);
    tbl[1]  = v(1,0,0,1, 1,0,0,16,0,1,0,0);
    tbl[2]  = v(1,0,0,1, 1,0,0,16,0,1,0,0);
    tbl[3]  = v(1,0,0,1, 1,0,0,16,0,1,0,0);
    tbl[4]  = v(1,0,1,0, 1,0,0,16,0,1,0,0);
    tbl[5]  = v(1,0,1,0, 1,1,0,15,0,0,0,0);
    tbl[6]  = v(1,0,1,1, 1,2,0,14,0,0,0,0);
    tbl[7]  = v(1,0,1,0, 1,3,1,14,0,0,0,0);
    tbl[8]  = v(1,0,1,0, 1,4,1,13,0,0,0,0);
    tbl[9]  = v(1,0,1,0, 1,5,1,12,0,0,0,0);
    tbl[10] = v(1,1,1,1, 0,6,1,11,0,0,1,0);
    tbl[11] = v(1,0,1,1, 0,0,0,16,0,1,1,1);
    tbl[12] = v(1,0,0,1, 0,0,0,16,0,1,0,1);
    tbl[13] = v(1,0,1,0, 1,0,0,16,0,1,0,0);
    tbl[14] = v(1,1,0,0, 0,1,0,15,0,0,0,0);
    tbl[15] = v(1,0,0,0, 0,0,0,16,0,1,0,1);
    tbl[16] = v(1,1,0,0, 0,0,0,16,0,1,0,1);
    tbl[17] = v(1,0,0,0, 0,0,0,16,0,1,0,1);
    tbl[18] = v(1,0,0,0, 0,0,0,16,0,1,0,1);
    tbl[19] = v(1,0,0,0, 1,0,0,16,0,1,0,0);
    tbl[20] = v(1,1,0,0, 0,0,0,16,0,1,0,0);
    tbl[21] = v(0,1,0,0, 0,0,0,16,0,1,0,1);
    tbl[22] = v(1,0,0,0, 1,0,0,16,0,1,0,0);
    tbl[23] = v(1,0,1,0, 1,0,0,16,0,1,0,0);
    tbl[24] = v(1,0,0,0, 1,1,0,15,0,0,0,0);
    #1;
    drive(0, 0, 0, 0);
    adv();
    drive(0, 1, 1, 1);
    adv();
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rs, tbl[i].fl, tbl[i].av, tbl[i].ce);
      chk($sformatf("row%0d", i), 32'(outs()), 32'(tbl[i][17:0]));
      adv();
    end
    // fill from reset
    drive(0, 0, 0, 0);
    adv();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, 0);
      chk($sformatf("fill_idx%0d", i), 32'(bus.alloc_index), 32'(i));
      chk($sformatf("fill_rdy%0d", i), 32'(bus.alloc_ready), 32'd1);
      adv();
    end
    drive(1, 0, 1, 0);
    chk("full_flags", 32'({bus.rob_full, bus.free_count, bus.alloc_ready, bus.stall_idrob}), 32'({1'b1, 5'd0, 1'b0, 1'b1}));
    adv();
    drive(1, 0, 0, 0);
    chk("full_hold", 32'({bus.alloc_index, bus.free_count, bus.rob_full}), 32'({4'd0, 5'd0, 1'b1}));
    adv();
    drive(1, 0, 1, 1);
    chk("full_simul_stall", 32'(bus.stall_idrob), 32'd1);
    adv();
    drive(1, 0, 1, 0);
    chk("after_simul", 32'({bus.commit_index, bus.free_count, bus.alloc_ready, bus.alloc_index}), 32'({4'd1, 5'd1, 1'b1, 4'd0}));
    adv();
    drive(1, 0, 0, 0);
    chk("refull", 32'({bus.rob_full, bus.alloc_index}), 32'({1'b1, 4'd1}));
    adv();
    drive(0, 0, 1, 1);
    adv();
    drive(1, 0, 0, 0);
    chk("reset_full", 32'(outs()), 32'(RST_OUT));
    // wrap-around
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 1, 0);
      adv();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 1);
      chk($sformatf("drain_ci%0d", i), 32'(bus.commit_index), 32'(i));
      adv();
    end
    drive(1, 0, 0, 1);
    chk("drained_empty", 32'({bus.rob_empty, bus.free_count, bus.commit_index}), 32'({1'b1, 5'd16, 4'd12}));
    adv();
    drive(1, 0, 0, 0);
    chk("empty_commit_ignored", 32'({bus.rob_empty, bus.commit_index}), 32'({1'b1, 4'd12}));
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 0);
      chk($sformatf("wrap_idx%0d", i), 32'(bus.alloc_index), 32'((12 + i) % 16));
      adv();
    end
    drive(1, 0, 0, 0);
    chk("wrapped_tail", 32'({bus.alloc_index, bus.free_count}), 32'({4'd4, 5'd8}));
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 0);
      adv();
    end
    drive(1, 0, 1, 0);
    chk("wrap_full", 32'({bus.rob_full, bus.rob_empty, bus.free_count, bus.alloc_index, bus.stall_idrob}),
        32'({1'b1, 1'b0, 5'd0, 4'd12, 1'b1}));
    adv();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
